// File: rtl/vga_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | vga_pkg : shared mode constants, delay-tap type and sizing helpers  |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
package vga_pkg;

   typedef struct packed {
      int   h_active;
      int   h_fp;
      int   h_sync;
      int   h_bp;
      int   v_active;
      int   v_fp;
      int   v_sync;
      int   v_bp;
      logic hs_pol;
      logic vs_pol;
      int   pclk_hz;
   } vga_mode_t;

   // 800x600@72 with a 50 MHz pixel clock
   localparam vga_mode_t MODE_SVGA = '{
      h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
      v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
      hs_pol: 1'b1, vs_pol: 1'b1, pclk_hz: 50_000_000
   };

   // 640x480@60 with a 25 MHz pixel clock
   localparam vga_mode_t MODE_VGA = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
      hs_pol: 1'b0, vs_pol: 1'b0, pclk_hz: 25_000_000
   };

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
      logic first;
   } vga_tap_t;

   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int cnt_width(input int total);
      return (total < 2) ? 1 : $clog2(total);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | vga_axis_counter : one timing axis (position, active, sync, wrap)   |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter  int ACTIVE = 800,
   parameter  int FP     = 56,
   parameter  int SYNC   = 120,
   parameter  int BP     = 64,
   localparam int TOTAL  = axis_total(ACTIVE, FP, SYNC, BP),
   localparam int W      = cnt_width(TOTAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step_i,
   output logic [W-1:0] count_o,
   output logic         active_o,
   output logic         in_sync_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (step_i) begin
         count_d = wrap_o ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign wrap_o    = (count_q == LAST);
   assign active_o  = (count_q < ACT_END);
   assign in_sync_o = (count_q >= SYNC_LO) && (count_q <= SYNC_HI);

endmodule
`default_nettype wire

// File: rtl/vga_param.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | vga_param : programmable VGA timing with fetch-latency realignment  |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module vga_param
   import vga_pkg::*;
#(
   parameter  int H_ACTIVE  = MODE_SVGA.h_active,
   parameter  int H_FP      = MODE_SVGA.h_fp,
   parameter  int H_SYNC    = MODE_SVGA.h_sync,
   parameter  int H_BP      = MODE_SVGA.h_bp,
   parameter  int V_ACTIVE  = MODE_SVGA.v_active,
   parameter  int V_FP      = MODE_SVGA.v_fp,
   parameter  int V_SYNC    = MODE_SVGA.v_sync,
   parameter  int V_BP      = MODE_SVGA.v_bp,
   parameter  bit HS_POL    = MODE_SVGA.hs_pol,
   parameter  bit VS_POL    = MODE_SVGA.vs_pol,
   parameter  int CB        = 2,
   parameter  int FETCH_LAT = 1,
   localparam int H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int HW        = cnt_width(H_TOTAL),
   localparam int VW        = cnt_width(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [3*CB-1:0] pixel,
   output logic [CB-1:0] red,
   output logic [CB-1:0] green,
   output logic [CB-1:0] blue,
   output logic          hsync,
   output logic          vsync,
   output logic          blank,
   output logic          frame_start,
   output logic [HW-1:0] nextH,
   output logic [VW-1:0] nextV,
   output logic          nextActive
);

   logic [HW-1:0] h_count;
   logic [VW-1:0] v_count;
   logic          h_active, h_sync, h_wrap;
   logic          v_active, v_sync, v_wrap_unused;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .step_i    (en),
      .count_o   (h_count),
      .active_o  (h_active),
      .in_sync_o (h_sync),
      .wrap_o    (h_wrap)
   );

   // The line counter steps only when the pixel counter wraps, so both wrap together.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .step_i    (en & h_wrap),
      .count_o   (v_count),
      .active_o  (v_active),
      .in_sync_o (v_sync),
      .wrap_o    (v_wrap_unused)
   );

   assign nextH      = h_count;
   assign nextV      = v_count;
   assign nextActive = h_active & v_active;

   vga_tap_t tap_now;
   vga_tap_t tap_dly;

   always_comb begin
      tap_now.hs     = h_sync;
      tap_now.vs     = v_sync;
      tap_now.active = h_active & v_active;
      tap_now.first  = (h_count == '0) && (v_count == '0);
   end

   generate
      if (FETCH_LAT == 0) begin : g_lat_wire
         assign tap_dly = tap_now;
      end else begin : g_lat_pipe
         vga_tap_t dly_q [FETCH_LAT];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < FETCH_LAT; i++) begin
                  dly_q[i] <= '0;
               end
            end else if (en) begin
               dly_q[0] <= tap_now;
               for (int i = 1; i < FETCH_LAT; i++) begin
                  dly_q[i] <= dly_q[i-1];
               end
            end
         end

         assign tap_dly = dly_q[FETCH_LAT-1];
      end
   endgenerate

   logic [CB-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          blank_q, blank_d, frame_start_q, frame_start_d;

   // frame_start is a single-clock pulse, so it drops even on idle clocks.
   always_comb begin
      red_d         = red_q;
      green_d       = green_q;
      blue_d        = blue_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      blank_d       = blank_q;
      frame_start_d = 1'b0;
      if (en) begin
         red_d         = tap_dly.active ? pixel[3*CB-1 -: CB] : '0;
         green_d       = tap_dly.active ? pixel[2*CB-1 -: CB] : '0;
         blue_d        = tap_dly.active ? pixel[CB-1:0]       : '0;
         hsync_d       = tap_dly.hs ? HS_POL : ~HS_POL;
         vsync_d       = tap_dly.vs ? VS_POL : ~VS_POL;
         blank_d       = ~tap_dly.active;
         frame_start_d = tap_dly.first;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         blank_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_param.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_vga_param : four vga_param configurations against a closed-form  |
// | position model. Revision: 1.0                                       |
// +---------------------------------------------------------------------+
module tb_vga_param;

   typedef struct packed {
      logic [1:0]  r;
      logic [1:0]  g;
      logic [1:0]  b;
      logic        hs;
      logic        vs;
      logic        bl;
      logic        fs;
      logic [15:0] nh;
      logic [15:0] nv;
      logic        na;
   } exp_t;

   logic clk;
   logic rst;
   logic en;
   bit   checking;
   int   n_tick;
   bit   last_en;
   int   tests;
   int   failed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pattern shown for position (h,v): 0 = constant white, 1 = column, 2 = mixed.
   function automatic logic [5:0] pat(input int psel, input int h, input int v);
      case (psel)
         0:       return 6'h3F;
         1:       return 6'(h);
         default: return 6'(h * 5 + v * 7);
      endcase
   endfunction

   // Pixel to present during the upcoming tick: data for the position issued lat ticks earlier.
   function automatic logic [5:0] pix_for(input int ht, input int vt, input int lat,
                                          input int psel, input int nt);
      int k;
      k = nt - lat;
      if (k < 0) return 6'h15;
      return pat(psel, k % ht, (k / ht) % vt);
   endfunction

   function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input int lat, input bit hp, input bit vp,
                                  input int psel, input int nt, input bit le);
      exp_t e;
      int ht, vt, frame, pos, k, h, v;
      bit act;
      logic [5:0] px;
      ht    = ha + hf + hsw + hb;
      vt    = va + vf + vsw + vb;
      frame = ht * vt;
      pos   = nt % frame;
      e.nh  = 16'(pos % ht);
      e.nv  = 16'(pos / ht);
      e.na  = ((pos % ht) < ha) && ((pos / ht) < va);
      k     = nt - 1 - lat;
      if (k < 0) begin
         e.r = 2'b00; e.g = 2'b00; e.b = 2'b00;
         e.hs = ~hp; e.vs = ~vp; e.bl = 1'b1; e.fs = 1'b0;
      end else begin
         h    = k % ht;
         v    = (k / ht) % vt;
         act  = (h < ha) && (v < va);
         px   = act ? pat(psel, h, v) : 6'h00;
         e.r  = px[5:4];
         e.g  = px[3:2];
         e.b  = px[1:0];
         e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
         e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
         e.bl = ~act;
         e.fs = le && (k % frame == 0);
      end
      return e;
   endfunction

   // A: small mode, latency 1, active-high syncs, constant white
   logic [5:0] pixA;
   logic [1:0] rA, gA, bA;
   logic hsA, vsA, blA, fsA, naA;
   logic [3:0] nhA;
   logic [2:0] nvA;
   assign pixA = pix_for(15, 8, 1, 0, n_tick);
   vga_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
               .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
               .HS_POL(1'b1), .VS_POL(1'b1), .CB(2), .FETCH_LAT(1)) u_a (
      .clk(clk), .rst(rst), .en(en), .pixel(pixA),
      .red(rA), .green(gA), .blue(bA), .hsync(hsA), .vsync(vsA), .blank(blA),
      .frame_start(fsA), .nextH(nhA), .nextV(nvA), .nextActive(naA));

   // B: wider line, latency 3, active-low syncs, column pattern
   logic [5:0] pixB;
   logic [1:0] rB, gB, bB;
   logic hsB, vsB, blB, fsB, naB;
   logic [5:0] nhB;
   logic [2:0] nvB;
   assign pixB = pix_for(48, 8, 3, 1, n_tick);
   vga_param #(.H_ACTIVE(40), .H_FP(3), .H_SYNC(4), .H_BP(1),
               .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
               .HS_POL(1'b0), .VS_POL(1'b0), .CB(2), .FETCH_LAT(3)) u_b (
      .clk(clk), .rst(rst), .en(en), .pixel(pixB),
      .red(rB), .green(gB), .blue(bB), .hsync(hsB), .vsync(vsB), .blank(blB),
      .frame_start(fsB), .nextH(nhB), .nextV(nvB), .nextActive(naB));

   // Z: zero latency, mixed sync polarity, mixed pattern
   logic [5:0] pixZ;
   logic [1:0] rZ, gZ, bZ;
   logic hsZ, vsZ, blZ, fsZ, naZ;
   logic [3:0] nhZ;
   logic [2:0] nvZ;
   assign pixZ = pix_for(15, 8, 0, 2, n_tick);
   vga_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
               .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
               .HS_POL(1'b1), .VS_POL(1'b0), .CB(2), .FETCH_LAT(0)) u_z (
      .clk(clk), .rst(rst), .en(en), .pixel(pixZ),
      .red(rZ), .green(gZ), .blue(bZ), .hsync(hsZ), .vsync(vsZ), .blank(blZ),
      .frame_start(fsZ), .nextH(nhZ), .nextV(nvZ), .nextActive(naZ));

   // C: default SVGA parameters
   logic [5:0] pixC;
   logic [1:0] rC, gC, bC;
   logic hsC, vsC, blC, fsC, naC;
   logic [10:0] nhC;
   logic [9:0]  nvC;
   assign pixC = pix_for(1040, 666, 1, 2, n_tick);
   vga_param u_c (
      .clk(clk), .rst(rst), .en(en), .pixel(pixC),
      .red(rC), .green(gC), .blue(bC), .hsync(hsC), .vsync(vsC), .blank(blC),
      .frame_start(fsC), .nextH(nhC), .nextV(nvC), .nextActive(naC));

   always @(posedge clk) begin
      if (rst) begin
         n_tick  <= 0;
         last_en <= 1'b0;
      end else if (en) begin
         n_tick  <= n_tick + 1;
         last_en <= 1'b1;
      end else begin
         last_en <= 1'b0;
      end
   end

   task automatic cmp(input string nm, input exp_t got, input exp_t exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
      end
   endtask

   task automatic lit(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         failed++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         cmp("A", {rA, gA, bA, hsA, vsA, blA, fsA, 16'(nhA), 16'(nvA), naA},
             model(8, 2, 3, 2, 4, 1, 2, 1, 1, 1'b1, 1'b1, 0, n_tick, last_en));
         cmp("B", {rB, gB, bB, hsB, vsB, blB, fsB, 16'(nhB), 16'(nvB), naB},
             model(40, 3, 4, 1, 4, 1, 2, 1, 3, 1'b0, 1'b0, 1, n_tick, last_en));
         cmp("Z", {rZ, gZ, bZ, hsZ, vsZ, blZ, fsZ, 16'(nhZ), 16'(nvZ), naZ},
             model(8, 2, 3, 2, 4, 1, 2, 1, 0, 1'b1, 1'b0, 2, n_tick, last_en));
         cmp("C", {rC, gC, bC, hsC, vsC, blC, fsC, 16'(nhC), 16'(nvC), naC},
             model(800, 56, 120, 64, 600, 37, 6, 23, 1, 1'b1, 1'b1, 2, n_tick, last_en));
      end
   end

   task automatic step(input bit r, input bit e);
      rst = r;
      en  = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      tests    = 0;
      failed   = 0;
      checking = 1'b0;
      rst      = 1'b1;
      en       = 1'b0;
      step(1'b1, 1'b0);
      checking = 1'b1;
      step(1'b1, 1'b0);

      lit("rstC_nextH", int'(nhC), 0);
      lit("rstC_nextV", int'(nvC), 0);
      lit("rstC_nextActive", int'(naC), 1);
      lit("rstC_colour", int'({rC, gC, bC}), 0);
      lit("rstC_hsync", int'(hsC), 0);
      lit("rstC_vsync", int'(vsC), 0);
      lit("rstC_blank", int'(blC), 1);
      lit("rstC_frame_start", int'(fsC), 0);
      lit("rstB_hsync_lowpol", int'(hsB), 1);

      step(1'b1, 1'b1);
      for (int e = 1; e <= 800; e++) begin
         step(1'b0, 1'b1);
         if (e == 1) begin
            lit("A_fs_e1", int'(fsA), 0);
            lit("Z_fs_e1", int'(fsZ), 1);
         end
         if (e == 2) begin
            lit("A_fs_e2", int'(fsA), 1);
            lit("A_blank_e2", int'(blA), 0);
            lit("A_colour_e2", int'({rA, gA, bA}), 6'h3F);
         end
         if (e == 3) begin
            lit("A_fs_e3", int'(fsA), 0);
            lit("B_blank_e3", int'(blB), 1);
         end
         if (e == 4) begin
            lit("B_blank_e4", int'(blB), 0);
            lit("B_fs_e4", int'(fsB), 1);
         end
         if (e == 5) begin
            lit("B_col1_e5", int'({rB, gB, bB}), 1);
            lit("C_nextH_e5", int'(nhC), 5);
         end
         if (e == 11) lit("A_hsync_e11", int'(hsA), 0);
         if (e == 12) lit("A_hsync_e12", int'(hsA), 1);
         if (e == 38) lit("B_col34_e38", int'({rB, gB, bB}), 34);
         if (e == 46) lit("B_hsync_e46", int'(hsB), 1);
         if (e == 47) lit("B_hsync_e47", int'(hsB), 0);
      end

      for (int i = 0; i < 800; i++) begin
         step(1'b0, (i % 2) == 0);
      end

      repeat (37) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      lit("mid_rst_nextH", int'(nhA), 0);
      lit("mid_rst_blank", int'(blA), 1);
      lit("mid_rst_C_nextV", int'(nvC), 0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      lit("mid_rst_fs_e1", int'(fsA), 0);
      step(1'b0, 1'b1);
      lit("mid_rst_fs_e2", int'(fsA), 1);

      for (int i = 0; i < 600; i++) begin
         step(1'b0, $urandom_range(0, 3) != 0);
      end

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_param.md
# vga_param

Parametrised successor to the fixed-mode VGA output stage. It generates programmable horizontal/vertical timing with selectable sync polarity and per-channel colour depth. It issues look-ahead pixel coordinates to the frame-buffer/sprite logic and re-aligns sync and blanking to a configurable fetch latency. It sits between the pixel-source logic and the board VGA pins, and adds blanking and frame-start outputs for downstream logic.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (ticks)
- H_SYNC, 120, hsync width (ticks)
- H_BP, 64, horizontal back porch (ticks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- CB, 2, bits per colour channel
- FETCH_LAT, 1, en ticks from coordinate presentation to pixel valid (0..15)
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous reset, active-high
- en  in  1  pixel-tick enable; all state advances only on clk edges with en=1
- pixel  in  3*CB  colour for the coordinate issued FETCH_LAT ticks earlier; {R,G,B}, R in MSBs
- red, green, blue  out  CB each  registered colour outputs
- hsync, vsync  out  1  registered sync outputs, polarity per HS_POL/VS_POL
- blank  out  1  registered; 1 outside the active area
- frame_start  out  1  one-clk pulse with the output of pixel (0,0)
- nextH  out  HW  look-ahead column (counter value)
- nextV  out  VW  look-ahead line
- nextActive  out  1  (nextH < H_ACTIVE) && (nextV < V_ACTIVE)

## Operation
- Counter h runs 0..H_TOTAL-1. On wrap, h returns to 0 and v increments. v wraps from V_TOTAL-1 to 0 on the same tick that h wraps.
- Horizontal sync window: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Vertical window is analogous in v.
- nextH/nextV/nextActive are driven directly from the counter registers, with no extra register stage.
- Delay line: FETCH_LAT stages, each holding {hs, vs, active, first}. It shifts only on en ticks. For FETCH_LAT=0 the line is a wire.
- Output register on an en tick:
  - colour ← active_d ? pixel : 0
  - hsync/vsync ← active level when inside the delayed window, else inactive
  - blank ← ~active_d
- frame_start is set on the en tick whose delayed position is (0,0). It clears on the next clk edge regardless of en.
- en=0: counters, delay line and all outputs hold. The exception is frame_start, which clears.
- Reset state:
  - h=v=0, so nextH=0, nextV=0, nextActive=1
  - colour=0, hsync=~HS_POL, vsync=~VS_POL, blank=1, frame_start=0
  - delay-line stages are reset to inactive/blank
- Reset mid-frame takes effect on the next edge. Timing restarts from (0,0), and no partial-line state survives.

## Timing
- Position P is presented on nextH/nextV during en tick t. The pixel for P is sampled at tick t+FETCH_LAT. All outputs for P become visible after that edge.
- After rst deasserts with en held high, frame_start rises after FETCH_LAT+1 clk edges.
- The line period is H_TOTAL en ticks and the frame period is H_TOTAL*V_TOTAL en ticks, exactly, with no gaps.
- Coordinate arithmetic is unsigned, width HW/VW. Wrap compares use TOTAL-1 and never rely on overflow.

## Structure
- Package vga_pkg holds:
  - mode constant sets: SVGA 800x600@72 (50 MHz) and VGA 640x480@60 (25 MHz)
  - a helper function for the total/width calculation
- Sub-module vga_axis_counter is instantiated once per axis. Its parameters are ACTIVE/FP/SYNC/BP. It has inputs step and rst, and outputs count, active, in_sync and wrap.

## Test plan
- Reset, default params: all outputs at the reset values above; nextH=0, nextV=0, nextActive=1.
- Active/blank: en=1, pixel=6'h3F, FETCH_LAT=1. Per line: colour=2'b11 and blank=0 for 800 clks, then 0 and blank=1 for 240 clks. hsync is high for 120 clks, starting 856 clks after the first active output.
- Vertical: vsync is high for 6240 clks, beginning 637*1040 clks after frame_start. frame_start repeats every 692640 clks.
- Enable gating: en alternating 1/0 doubles every period above. Outputs are stable during en=0 cycles.
- Latency: FETCH_LAT=3, pixel = nextH[5:0] delayed 3 en ticks. Each displayed column c shows {R,G,B}=c[5:0], and column 0 coincides with blank falling.
- Mid-frame reset: rst pulsed at line 300. Outputs take reset values on the next edge, and frame_start fires FETCH_LAT+1 edges after release.
